// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared widths, opcodes and payload types for the ALU arbiter
package alu_arb_pkg;
  localparam int DATA_W   = 32;
  localparam int OP_W     = 5;
  localparam int SHAMT_W  = 5;
  localparam int MAX_ID_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB = 5'd1;
  localparam logic [OP_W-1:0] OP_AND = 5'd2;
  localparam logic [OP_W-1:0] OP_OR  = 5'd3;
  localparam logic [OP_W-1:0] OP_SLL = 5'd4;
  localparam logic [OP_W-1:0] OP_SRA = 5'd5;

  typedef struct packed {
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;
    logic [OP_W-1:0]    op;
    logic [SHAMT_W-1:0] shamt;
  } alu_req_t;

  // id is sized for the largest supported requester count (8)
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [DATA_W-1:0]   result;
    logic                ne;
    logic                lt;
    logic                ovf;
  } alu_rsp_t;
endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational cyclic first-set picker starting at ptr
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);
  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    // Walk from farthest to nearest so the closest requester at/after ptr wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin two-stage sharing of one combinational ALU
// Optional grant/stall counters under ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA_W-1:0]    req_a,
  input  logic [NREQ*DATA_W-1:0]    req_b,
  input  logic [NREQ*OP_W-1:0]      req_op,
  input  logic [NREQ*SHAMT_W-1:0]   req_shamt,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  output logic [SHAMT_W-1:0]        alu_shamt,
  input  logic [DATA_W-1:0]         alu_res,
  input  logic                      alu_ne,
  input  logic                      alu_lt,
  input  logic                      alu_ovf,
`ifdef ALU_ARB_STATS_EN
  input  logic [IDW-1:0]            stat_sel,
  output logic [15:0]               stat_grants,
  output logic [15:0]               stat_stalls,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [IDW-1:0]            rsp_id,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_ne,
  output logic                      rsp_lt,
  output logic                      rsp_ovf
);
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            iss_valid;
  logic [IDW-1:0]  iss_id;
  alu_req_t        iss_q;
  alu_req_t        sel_req;
  alu_rsp_t        rsp_q;
  logic            iss_adv;
  logic            issue_free;
  logic            accept;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign iss_adv    = iss_valid & (~rsp_valid | rsp_ready);
  assign issue_free = ~iss_valid | iss_adv;
  // reset_n gates ready so nothing appears accepted while reset is held
  assign req_ready  = grant & {NREQ{issue_free & reset_n}};
  assign accept     = |req_ready;

  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_req.a     = req_a[i*DATA_W +: DATA_W];
        sel_req.b     = req_b[i*DATA_W +: DATA_W];
        sel_req.op    = req_op[i*OP_W +: OP_W];
        sel_req.shamt = req_shamt[i*SHAMT_W +: SHAMT_W];
      end
    end
  end

  assign alu_a     = iss_valid ? iss_q.a     : '0;
  assign alu_b     = iss_valid ? iss_q.b     : '0;
  assign alu_op    = iss_valid ? iss_q.op    : '0;
  assign alu_shamt = iss_valid ? iss_q.shamt : '0;

  assign rsp_id     = IDW'(rsp_q.id);
  assign rsp_result = rsp_q.result;
  assign rsp_ne     = rsp_q.ne;
  assign rsp_lt     = rsp_q.lt;
  assign rsp_ovf    = rsp_q.ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      iss_valid <= 1'b0;
      iss_id    <= '0;
      iss_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      if (accept) begin
        iss_valid <= 1'b1;
        iss_q     <= sel_req;
        iss_id    <= grant_id;
        ptr       <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
      end else if (iss_adv) begin
        iss_valid <= 1'b0;
      end

      if (iss_adv) begin
        rsp_valid    <= 1'b1;
        rsp_q.id     <= MAX_ID_W'(iss_id);
        rsp_q.result <= alu_res;
        rsp_q.ne     <= alu_ne;
        rsp_q.lt     <= alu_lt;
        rsp_q.ovf    <= alu_ovf;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt [NREQ];
  logic [15:0] stall_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && grant_cnt[i] != 16'hFFFF) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
      if ((|req_valid) && !issue_free && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stat_grants = (int'(stat_sel) < NREQ) ? grant_cnt[stat_sel] : 16'd0;
  assign stat_stalls = stall_cnt;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                    clock = 1'b0;
  logic                    reset_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*32-1:0]      req_a, req_b;
  logic [NREQ*5-1:0]       req_op, req_shamt;
  logic [31:0]             alu_a, alu_b, alu_res;
  logic [4:0]              alu_op, alu_shamt;
  logic                    alu_ne, alu_lt, alu_ovf;
  logic                    rsp_valid, rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic [31:0]             rsp_result;
  logic                    rsp_ne, rsp_lt, rsp_ovf;
`ifdef ALU_ARB_STATS_EN
  logic [IDW-1:0]          stat_sel = '0;
  logic [15:0]             stat_grants, stat_stalls;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_shamt  (req_shamt),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_shamt  (alu_shamt),
    .alu_res    (alu_res),
    .alu_ne     (alu_ne),
    .alu_lt     (alu_lt),
    .alu_ovf    (alu_ovf),
`ifdef ALU_ARB_STATS_EN
    .stat_sel   (stat_sel),
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_ne     (rsp_ne),
    .rsp_lt     (rsp_lt),
    .rsp_ovf    (rsp_ovf)
  );

  // The processor's shared ALU, as seen from the arbiter.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ne  = (alu_a != alu_b);
    alu_lt  = ($signed(alu_a) < $signed(alu_b));
    case (alu_op)
      OP_ADD: begin
        alu_res = alu_a + alu_b;
        alu_ovf = (alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]);
      end
      OP_SUB: begin
        alu_res = alu_a - alu_b;
        alu_ovf = (alu_a[31] != alu_b[31]) && (alu_res[31] != alu_a[31]);
      end
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_SLL: alu_res = alu_a << alu_shamt;
      OP_SRA: alu_res = $unsigned($signed(alu_a) >>> alu_shamt);
      default: alu_res = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  logic        mid_valid;
  logic        got_valid;
  logic [1:0]  got_id;
  logic [31:0] got_res;
  logic        got_ne, got_lt, got_ovf;

  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic [4:0] sh);
    req_a[id*32 +: 32]   = a;
    req_b[id*32 +: 32]   = b;
    req_op[id*5 +: 5]    = op;
    req_shamt[id*5 +: 5] = sh;
    req_valid            = 4'b0001 << id;
    rsp_ready            = 1'b1;
    @(posedge clock); #1;
    req_valid = '0;
    mid_valid = rsp_valid;
    @(posedge clock); #1;
    got_valid = rsp_valid;
    got_id    = rsp_id;
    got_res   = rsp_result;
    got_ne    = rsp_ne;
    got_lt    = rsp_lt;
    got_ovf   = rsp_ovf;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepts;
    reset_n   = 1'b0;
    req_valid = '1;
    req_a = '0; req_b = '0; req_op = '0; req_shamt = '0;
    rsp_ready = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n   = 1'b1;
    req_valid = '0;
    @(posedge clock); #1;

    run_op(2, 32'd5, 32'd7, OP_ADD, 5'd0);
    check("add_mid_valid", 32'(mid_valid), 32'd0);
    check("add_valid", 32'(got_valid), 32'd1);
    check("add_id", 32'(got_id), 32'd2);
    check("add_res", got_res, 32'd12);

    run_op(0, 32'h7FFF_FFFF, 32'd1, OP_ADD, 5'd0);
    check("ovf_id", 32'(got_id), 32'd0);
    check("ovf_res", got_res, 32'h8000_0000);
    check("ovf_flag", 32'(got_ovf), 32'd1);

    run_op(1, 32'd3, 32'd5, OP_SUB, 5'd0);
    check("sub_lt_res", got_res, 32'hFFFF_FFFE);
    check("sub_lt_ne", 32'(got_ne), 32'd1);
    check("sub_lt_lt", 32'(got_lt), 32'd1);

    run_op(3, 32'd9, 32'd9, OP_SUB, 5'd0);
    check("sub_eq_res", got_res, 32'd0);
    check("sub_eq_ne", 32'(got_ne), 32'd0);
    check("sub_eq_lt", 32'(got_lt), 32'd0);
    check("sub_eq_ovf", 32'(got_ovf), 32'd0);

    run_op(2, 32'd1, 32'd0, OP_SLL, 5'd4);
    check("sll_res", got_res, 32'h0000_0010);
    run_op(3, 32'h8000_0000, 32'd0, OP_SRA, 5'd4);
    check("sra_res", got_res, 32'hF800_0000);
    check("sra_id", 32'(got_id), 32'd3);

    // Round-robin: every requester asks, each tagged by a distinct operand.
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*32 +: 32]   = 32'(100 + i);
      req_b[i*32 +: 32]   = 32'(i);
      req_op[i*5 +: 5]    = OP_ADD;
      req_shamt[i*5 +: 5] = 5'd0;
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clock);
      if (cyc < 8) check($sformatf("rr_acc%0d", cyc), 32'(req_ready), 32'(4'b0001 << (cyc % 4)));
      if (cyc >= 2) begin
        check($sformatf("rr_rv%0d", cyc), 32'(rsp_valid), 32'd1);
        check($sformatf("rr_id%0d", cyc), 32'(rsp_id), 32'((cyc - 2) % 4));
        check($sformatf("rr_res%0d", cyc), rsp_result, 32'(100 + 2 * ((cyc - 2) % 4)));
      end
      @(posedge clock); #1;
      if (cyc == 7) req_valid = '0;
    end

    // Backpressure: response held for three cycles under continuous requests.
    rsp_ready = 1'b0;
    req_valid = '1;
    accepts   = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (req_ready != '0) accepts++;
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("bp_accepts", 32'(accepts), 32'd2);
    check("bp_ready", 32'(req_ready), 32'd0);
    check("bp_rv", 32'(rsp_valid), 32'd1);
    check("bp_id", 32'(rsp_id), 32'd0);
    check("bp_res", rsp_result, 32'd100);
    check("bp_iss_a", alu_a, 32'd101);
    rsp_ready = 1'b1;
    req_valid = '0;
    @(posedge clock); #1;
    check("bp_rel_rv", 32'(rsp_valid), 32'd1);
    check("bp_rel_id", 32'(rsp_id), 32'd1);
    check("bp_rel_res", rsp_result, 32'd102);
    @(posedge clock); #1;
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Reset with both stages full and pointer away from 0.
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    repeat (2) @(posedge clock);
    #1;
    check("full_rv", 32'(rsp_valid), 32'd1);
    check("full_iss", alu_a, 32'd101);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_rv", 32'(rsp_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    check("arst_alu_a", alu_a, 32'd0);
    check("arst_res", rsp_result, 32'd0);
    req_valid = '1;
    rsp_ready = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_grant", 32'(req_ready), 32'b0001);
    @(posedge clock); #1;
    req_valid = '0;
    @(posedge clock); #1;
    check("post_rst_rv", 32'(rsp_valid), 32'd1);
    check("post_rst_id", 32'(rsp_id), 32'd0);
    check("post_rst_res", rsp_result, 32'd100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
